mv_median_filter: RTL and testbench

- Streaming post-filter directly downstream of the three-step-search motion estimator.
- Consumes the per-block motion-vector field in raster order: BH x BV blocks, block 0 at top-left, x fastest.
- Emits the same field, same order, with each interior vector replaced by the component-wise 3x3 median of its neighbourhood. This removes isolated outlier vectors before vector output/file dump.

---
 rtl/mv_pkg.sv | 37 +++
 rtl/median9.sv | 37 +++
 rtl/mv_median_filter.sv | 189 ++++++++++++++++++
 tb/tb_mv_median_filter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mv_pkg : shared geometry, vector type, FSM encoding, output saturation |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
package mv_pkg;

  localparam int BH         = 40;
  localparam int BV         = 30;
  localparam int W          = 12;
  localparam int RANGE      = 7;
  localparam int FRAME_VECS = BH * BV;

  typedef logic signed [W-1:0] mv_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } mv_state_t;

  localparam mv_t c_MV_MAX = mv_t'(RANGE);
  localparam mv_t c_MV_MIN = mv_t'(-RANGE);

  function automatic mv_t mv_sat(input mv_t v);
    mv_t r;
    r = v;
    if (v > c_MV_MAX) begin
      r = c_MV_MAX;
    end else if (v < c_MV_MIN) begin
      r = c_MV_MIN;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/median9.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | median9 : combinational signed median of nine (19 compare-exchanges)   |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module median9
  import mv_pkg::*;
(
  input  mv_t d [9],
  output mv_t med
);

  // Exchange pairs (lo, hi); after the network slot 4 holds the median.
  localparam logic [3:0] c_CX_A [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
                                         4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
  localparam logic [3:0] c_CX_B [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
                                         4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

  mv_t w_p [9];
  mv_t w_t;

  always_comb begin
    w_p = d;
    w_t = '0;
    for (int i = 0; i < 19; i++) begin
      if (w_p[c_CX_A[i]] > w_p[c_CX_B[i]]) begin
        w_t              = w_p[c_CX_A[i]];
        w_p[c_CX_A[i]]   = w_p[c_CX_B[i]];
        w_p[c_CX_B[i]]   = w_t;
      end
    end
  end

  assign med = w_p[4];

endmodule
`default_nettype wire

// File: rtl/mv_median_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | mv_median_filter : streaming 3x3 component-wise median of MV field     |
// | Optional: define MV_CLAMP_EN to saturate outputs to [-RANGE, +RANGE].  |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module mv_median_filter
  import mv_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  mv_t  in_mv_x,
  input  mv_t  in_mv_y,
  output logic out_valid,
  input  logic out_ready,
  output mv_t  out_mv_x,
  output mv_t  out_mv_y,
  output logic out_eof
);

  localparam int c_TAPS = 2 * BH + 2;
  localparam int c_ICW  = $clog2(FRAME_VECS);
  localparam int c_XCW  = $clog2(BH);
  localparam int c_YCW  = $clog2(BV);
  localparam logic [c_ICW-1:0] c_IN_FILL_LAST = c_ICW'(BH + 1);
  localparam logic [c_ICW-1:0] c_IN_LAST      = c_ICW'(FRAME_VECS - 1);
  localparam logic [c_XCW-1:0] c_COL_LAST     = c_XCW'(BH - 1);
  localparam logic [c_YCW-1:0] c_ROW_LAST     = c_YCW'(BV - 1);

  mv_state_t        r_state;
  mv_state_t        w_state_nxt;
  logic             r_active;
  logic [c_ICW-1:0] r_in_cnt;
  logic [c_XCW-1:0] r_ocol;
  logic [c_YCW-1:0] r_orow;

  mv_t r_lx [c_TAPS];
  mv_t r_ly [c_TAPS];
  mv_t w_nx [c_TAPS+1];
  mv_t w_ny [c_TAPS+1];
  mv_t w_win_x [9];
  mv_t w_win_y [9];
  mv_t w_med_x, w_med_y;
  mv_t w_sel_x, w_sel_y;
  mv_t w_fin_x, w_fin_y;

  logic r_out_valid, r_out_eof;
  mv_t  r_out_x, r_out_y;

  logic w_slot_free, w_in_fire, w_out_fire;
  logic w_shift, w_load, w_border, w_last_out;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_out_fire  = r_out_valid && out_ready;
  assign in_ready    = r_active && ((r_state == FILL) || ((r_state == RUN) && w_slot_free));
  assign w_in_fire   = in_valid && in_ready;

  // Post-shift view: tap 0 is the incoming vector, the 3x3 centre sits at BH+1.
  always_comb begin
    w_nx[0] = in_mv_x;
    w_ny[0] = in_mv_y;
    for (int i = 1; i <= c_TAPS; i++) begin
      w_nx[i] = r_lx[i-1];
      w_ny[i] = r_ly[i-1];
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_win_x[3*r+c] = w_nx[r*BH+c];
        w_win_y[3*r+c] = w_ny[r*BH+c];
      end
    end
  end

  median9 u_med_x (.d(w_win_x), .med(w_med_x));
  median9 u_med_y (.d(w_win_y), .med(w_med_y));

  assign w_border   = (r_orow == '0) || (r_orow == c_ROW_LAST) ||
                      (r_ocol == '0) || (r_ocol == c_COL_LAST);
  assign w_last_out = (r_orow == c_ROW_LAST) && (r_ocol == c_COL_LAST);
  assign w_sel_x    = w_border ? w_nx[BH+1] : w_med_x;
  assign w_sel_y    = w_border ? w_ny[BH+1] : w_med_y;

`ifdef MV_CLAMP_EN
  assign w_fin_x = mv_sat(w_sel_x);
  assign w_fin_y = mv_sat(w_sel_y);
`else
  assign w_fin_x = w_sel_x;
  assign w_fin_y = w_sel_y;
`endif

  // Line buffers as shift chains; drain steps shift filler so the centre tap stays aligned.
  always_ff @(posedge clk) begin
    if (w_shift) begin
      for (int i = 0; i < c_TAPS; i++) begin
        r_lx[i] <= w_nx[i];
        r_ly[i] <= w_ny[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_in_fire) begin
          w_shift = 1'b1;
          if (r_in_cnt == c_IN_FILL_LAST) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (w_in_fire) begin
          w_shift = 1'b1;
          w_load  = 1'b1;
          if (r_in_cnt == c_IN_LAST) begin
            w_state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_slot_free && !(r_out_valid && r_out_eof)) begin
          w_shift = 1'b1;
          w_load  = 1'b1;
        end
        if (w_out_fire && r_out_eof) begin
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active    <= 1'b0;
      r_in_cnt    <= '0;
      r_ocol      <= '0;
      r_orow      <= '0;
      r_out_valid <= 1'b0;
      r_out_eof   <= 1'b0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else begin
      r_active <= 1'b1;
      if (w_in_fire) begin
        r_in_cnt <= (r_in_cnt == c_IN_LAST) ? '0 : r_in_cnt + 1'b1;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_eof   <= w_last_out;
        r_out_x     <= w_fin_x;
        r_out_y     <= w_fin_y;
        if (r_ocol == c_COL_LAST) begin
          r_ocol <= '0;
          r_orow <= (r_orow == c_ROW_LAST) ? '0 : r_orow + 1'b1;
        end else begin
          r_ocol <= r_ocol + 1'b1;
        end
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
        r_out_eof   <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_eof   = r_out_eof;
  assign out_mv_x  = r_out_x;
  assign out_mv_y  = r_out_y;

endmodule
`default_nettype wire

// File: tb/tb_mv_median_filter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_mv_median_filter : scoreboard bench for the MV median post-filter   |
// | Rev 1.0 - initial release                                              |
// +-----------------------------------------------------------------------+
module tb_mv_median_filter;
  import mv_pkg::*;

  typedef struct packed {
    mv_t  x;
    mv_t  y;
    logic eof;
  } exp_t;

`ifdef MV_CLAMP_EN
  localparam int c_IDX0_X = -7;
  localparam int c_IDX0_Y = 7;
`else
  localparam int c_IDX0_X = -12;
  localparam int c_IDX0_Y = 9;
`endif

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_eof;
  logic out_ready = 1'b1;
  mv_t  in_mv_x, in_mv_y, out_mv_x, out_mv_y;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t mon_e;
  mv_t  fx [FRAME_VECS];
  mv_t  fy [FRAME_VECS];
  int   n_acc, n_out, first_acc;
  bit   seen_first;
  bit   rdy_rand = 1'b0;
  bit   in_gaps = 1'b0;
  int   watch_idx = -1;
  mv_t  cap_x, cap_y;

  mv_median_filter dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mv_x  (in_mv_x),
    .in_mv_y  (in_mv_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_mv_x (out_mv_x),
    .out_mv_y (out_mv_y),
    .out_eof  (out_eof)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: border pass-through, interior sorted median, optional saturation.
  function automatic int model_comp(input int k, input bit use_y);
    int col, row, t, r, idx;
    int v [9];
    col = k % BH;
    row = k / BH;
    if (row == 0 || row == BV - 1 || col == 0 || col == BH - 1) begin
      r = use_y ? int'($signed(fy[k])) : int'($signed(fx[k]));
    end else begin
      for (int dr = -1; dr <= 1; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          idx = k + dr * BH + dc;
          v[(dr + 1) * 3 + (dc + 1)] = use_y ? int'($signed(fy[idx])) : int'($signed(fx[idx]));
        end
      end
      for (int i = 1; i < 9; i++) begin
        for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
          t      = v[j];
          v[j]   = v[j-1];
          v[j-1] = t;
        end
      end
      r = v[4];
    end
`ifdef MV_CLAMP_EN
    if (r > RANGE) r = RANGE;
    else if (r < -RANGE) r = -RANGE;
`endif
    return r;
  endfunction

  function automatic exp_t make_exp(input int k);
    exp_t e;
    e.x   = mv_t'(model_comp(k, 1'b0));
    e.y   = mv_t'(model_comp(k, 1'b1));
    e.eof = (k == FRAME_VECS - 1);
    return e;
  endfunction

  task automatic fill_zero();
    for (int k = 0; k < FRAME_VECS; k++) begin
      fx[k] = '0;
      fy[k] = '0;
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < FRAME_VECS; k++) begin
      fx[k] = mv_t'((k % BH) - 20);
      fy[k] = mv_t'((k / BH) - 15);
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_out_valid"}, int'(out_valid), 0);
    check_val({tag, "_out_x"}, int'($signed(out_mv_x)), 0);
    check_val({tag, "_out_y"}, int'($signed(out_mv_y)), 0);
    check_val({tag, "_out_eof"}, int'(out_eof), 0);
    check_val({tag, "_in_ready"}, int'(in_ready), 0);
  endtask

  // Called at posedge+1; pushes the expected output for each accepted input.
  task automatic drive(input int n);
    int k = 0;
    int budget = 0;
    bit acc;
    while (k < n && budget < 20000) begin
      if (in_gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_mv_x  = fx[k];
        in_mv_y  = fy[k];
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) q.push_back(make_exp(k));
      @(posedge clk);
      #1;
      if (acc) begin
        k++;
        n_acc++;
      end
      budget++;
    end
    in_valid = 1'b0;
    check_val("in_accepted", k, n);
  endtask

  task automatic wait_out(input int n);
    int cyc = 0;
    while (n_out < n && cyc < 5000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("out_count", n_out, n);
    repeat (4) @(negedge clk);
    check_val("out_extra", n_out, n);
    check_val("queue_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int n_drive, input bit full);
    n_acc      = 0;
    n_out      = 0;
    seen_first = 1'b0;
    cap_x      = mv_t'(999);
    cap_y      = mv_t'(999);
    drive(n_drive);
    if (full) wait_out(FRAME_VECS);
  endtask

  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (!seen_first) begin
        seen_first = 1'b1;
        first_acc  = n_acc;
      end
      if (q.size() == 0) begin
        check_val("spurious_out", q.size(), 1);
      end else begin
        mon_e = q[0];
        if (out_ready) begin
          void'(q.pop_front());
          if (n_out == watch_idx) begin
            cap_x = out_mv_x;
            cap_y = out_mv_y;
          end
          check_val("mv_x", int'($signed(out_mv_x)), int'($signed(mon_e.x)));
          check_val("mv_y", int'($signed(out_mv_y)), int'($signed(mon_e.y)));
          check_val("eof", int'(out_eof), int'(mon_e.eof));
          n_out++;
        end else begin
          check_val("stall_hold", int'({out_mv_x, out_mv_y, out_eof}),
                    int'({mon_e.x, mon_e.y, mon_e.eof}));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_mv_x  = '0;
    in_mv_y  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("in_ready_pre", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check_val("in_ready_rise", int'(in_ready), 1);

    // all-zero field, continuous ready
    fill_zero();
    run_frame(FRAME_VECS, 1'b1);
    check_val("first_latency", first_acc, BH + 2);

    // interior outlier removed
    fill_zero();
    fx[5*BH+5] = mv_t'(7);
    fy[5*BH+5] = mv_t'(-7);
    watch_idx = 5 * BH + 5;
    run_frame(FRAME_VECS, 1'b1);
    check_val("idx205_x", int'($signed(cap_x)), 0);
    check_val("idx205_y", int'($signed(cap_y)), 0);

    // border outlier passes through, random backpressure
    fill_zero();
    fx[10*BH] = mv_t'(3);
    fy[10*BH] = mv_t'(3);
    watch_idx = 10 * BH;
    rdy_rand  = 1'b1;
    run_frame(FRAME_VECS, 1'b1);
    check_val("idx400_x", int'($signed(cap_x)), 3);
    check_val("idx400_y", int'($signed(cap_y)), 3);

    // ramp field with input gaps and random backpressure
    fill_ramp();
    watch_idx = -1;
    in_gaps   = 1'b1;
    run_frame(FRAME_VECS, 1'b1);
    in_gaps   = 1'b0;

    // reset mid-frame, then a full zero frame
    run_frame(500, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("mid");
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_in_ready_pre", int'(in_ready), 0);
    @(posedge clk);
    #1;
    check_val("mid_in_ready_rise", int'(in_ready), 1);
    rdy_rand = 1'b0;
    fill_zero();
    run_frame(FRAME_VECS, 1'b1);

    // random field with a large border vector at index 0
    for (int k = 0; k < FRAME_VECS; k++) begin
      fx[k] = mv_t'(int'($urandom_range(0, 40)) - 20);
      fy[k] = mv_t'(int'($urandom_range(0, 40)) - 20);
    end
    fx[0] = mv_t'(-12);
    fy[0] = mv_t'(9);
    watch_idx = 0;
    rdy_rand  = 1'b1;
    run_frame(FRAME_VECS, 1'b1);
    check_val("idx0_x", int'($signed(cap_x)), c_IDX0_X);
    check_val("idx0_y", int'($signed(cap_y)), c_IDX0_Y);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
